// File: rtl/gpr_pkg.sv
// Shared constants and the address-compare helper used by the register file
// write decode and the read-port bypass logic.
package gpr_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;
  localparam int MAX_ADDR_W     = 16;

  typedef logic [MAX_ADDR_W-1:0] addr_wide_t;

  // Callers zero-extend to addr_wide_t; only the low 'width' bits take part in the compare.
  function automatic logic addr_eq(input addr_wide_t a, input addr_wide_t b, input int width);
    addr_wide_t mask;
    if (width >= MAX_ADDR_W) begin
      mask = '1;
    end else begin
      mask = (addr_wide_t'(1) << width) - addr_wide_t'(1);
    end
    return ((a ^ b) & mask) == '0;
  endfunction

endpackage

// File: rtl/gpr_rd_port.sv
// One combinational read port: array lookup, same-cycle write bypass,
// register-zero force and busy gating.
module gpr_rd_port
  import gpr_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     raddr,
  input  logic [DATA_W-1:0]     regs [2**ADDR_W],
  input  logic [2**ADDR_W-1:0]  busy,
  input  logic                  wen0,
  input  logic [ADDR_W-1:0]     waddr0,
  input  logic [DATA_W-1:0]     wdata0,
  input  logic                  wen1,
  input  logic [ADDR_W-1:0]     waddr1,
  input  logic [DATA_W-1:0]     wdata1,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rbusy
);

  localparam bit ZERO_ON = (ZERO_REG != 0);

  logic is_zero;
  logic hit0;
  logic hit1;

  // wen0/wen1 arrive already qualified (reset and register-zero writes removed),
  // so a hit here always means that data will commit at the coming edge.
  always_comb begin
    is_zero = ZERO_ON && (raddr == '0);
    hit0    = wen0 && addr_eq(addr_wide_t'(raddr), addr_wide_t'(waddr0), ADDR_W);
    hit1    = wen1 && addr_eq(addr_wide_t'(raddr), addr_wide_t'(waddr1), ADDR_W);
    rdata   = regs[raddr];
    rbusy   = busy[raddr];
    if (rst || is_zero) begin
      rdata = '0;
      rbusy = 1'b0;
    end else if (hit1) begin
      rdata = wdata1;
      rbusy = 1'b0;
    end else if (hit0) begin
      rdata = wdata0;
      rbusy = 1'b0;
    end
  end

endmodule

// File: rtl/gpr_mp.sv
// Multi-ported general purpose register file with two write ports,
// NUM_RD bypassed read ports and a per-register busy scoreboard.
module gpr_mp
  import gpr_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NUM_RD*ADDR_W-1:0] RAddr,
  output logic [NUM_RD*DATA_W-1:0] RData,
  output logic [NUM_RD-1:0]        RBusy,
  input  logic                     WEn0,
  input  logic [ADDR_W-1:0]        WAddr0,
  input  logic [DATA_W-1:0]        WData0,
  input  logic                     WEn1,
  input  logic [ADDR_W-1:0]        WAddr1,
  input  logic [DATA_W-1:0]        WData1,
  input  logic                     ResvEn,
  input  logic [ADDR_W-1:0]        ResvAddr
);

  localparam int DEPTH   = 2**ADDR_W;
  localparam bit ZERO_ON = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;

  logic             wen0_eff;
  logic             wen1_eff;
  logic             resv_eff;
  logic [DEPTH-1:0] wsel0;
  logic [DEPTH-1:0] wsel1;
  logic [DEPTH-1:0] rsel;

  // Qualify enables once so storage, scoreboard and bypass all agree on what commits.
  always_comb begin
    wen0_eff = WEn0   && !Reset && !(ZERO_ON && (WAddr0   == '0));
    wen1_eff = WEn1   && !Reset && !(ZERO_ON && (WAddr1   == '0));
    resv_eff = ResvEn && !Reset && !(ZERO_ON && (ResvAddr == '0));
    wsel0    = '0;
    wsel1    = '0;
    rsel     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wsel0[i] = wen0_eff && addr_eq(addr_wide_t'(WAddr0),   addr_wide_t'(i), ADDR_W);
      wsel1[i] = wen1_eff && addr_eq(addr_wide_t'(WAddr1),   addr_wide_t'(i), ADDR_W);
      rsel[i]  = resv_eff && addr_eq(addr_wide_t'(ResvAddr), addr_wide_t'(i), ADDR_W);
    end
  end

  // Port 1 wins a same-address write; a new reservation outranks the clear from a write.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wsel1[i]) begin
          regs[i] <= WData1;
        end else if (wsel0[i]) begin
          regs[i] <= WData0;
        end
        if (rsel[i]) begin
          busy[i] <= 1'b1;
        end else if (wsel0[i] || wsel1[i]) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    gpr_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rd_port (
      .rst    (Reset),
      .raddr  (RAddr[g*ADDR_W +: ADDR_W]),
      .regs   (regs),
      .busy   (busy),
      .wen0   (wen0_eff),
      .waddr0 (WAddr0),
      .wdata0 (WData0),
      .wen1   (wen1_eff),
      .waddr1 (WAddr1),
      .wdata1 (WData1),
      .rdata  (RData[g*DATA_W +: DATA_W]),
      .rbusy  (RBusy[g])
    );
  end

endmodule
